sorted_value_router: RTL
========================

SORTED_VALUE_ROUTER -- requirements
Module: sorted_value_router

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set entry width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set entry count; legal range 2..256.
REQ-003 Parameter CNT_W, default $clog2(DEPTH+1), SHALL set count/last_addr width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 op_valid  input  1  SHALL request an operation.
REQ-007 op  input  2  SHALL select: 00 insert, 01 remove-min, 10 clear, 11 reserved (treated as no-op with result=0).
REQ-008 op_data  input  DATA_W  SHALL carry the insert value; sampled only on accept.
REQ-009 op_ready  output  1  SHALL be high only in IDLE.
REQ-010 done  output  1  SHALL pulse one cycle at operation completion.
REQ-011 result  output  1  SHALL be valid with done: 1 success, 0 rejected.
REQ-012 data_out  output  DATA_W  SHALL hold removed or dropped value; valid with done.
REQ-013 min_out  output  DATA_W  SHALL show entry 0 combinationally.
REQ-014 count  output  CNT_W  SHALL show stored entries; full/empty outputs 1 bit each; last_addr output CNT_W = count-1, 0 when empty.

Function
REQ-015 Storage SHALL be a DEPTH-entry register array, ascending order, entry 0 minimum; unused entries hold sentinel all-ones.
REQ-016 Accept SHALL occur when op_valid && op_ready; op and op_data captured that cycle.
REQ-017 FSM states SHALL be IDLE, INSERT, REMOVE, FINISH; FINISH lasts one cycle, asserts done, returns to IDLE.
REQ-018 Insert into empty: IDLE->FINISH; entry 0 written; done at accept+1.
REQ-019 Insert non-empty: INSERT walks idx from count-1 downward, one compare per cycle; if entry[idx] > value, entry[idx+1]<=entry[idx]; else entry[idx+1]<=value and go FINISH.
REQ-020 On idx==0 with entry[0] > value, SHALL write entry[1]<=entry[0] and entry[0]<=value same cycle, then FINISH.
REQ-021 Compare SHALL be unsigned, strictly greater; equal values keep arrival order.
REQ-022 Insert latency: with k entries greater than value, done at accept+1+min(k+1,count) cycles.
REQ-023 Remove non-empty: data_out<=entry[0] at accept; REMOVE shifts entry[i]<=entry[i+1] for i=0..count-2, one per cycle, then entry[count-1]<=sentinel; done at accept+1+max(count-1,1).
REQ-024 count SHALL change by exactly 1 at the FINISH transition of a successful insert/remove.
REQ-025 Remove on empty: result=0, data_out=all-ones, done at accept+1, no state change.
REQ-026 Insert on full: behaviour per REQ-031/032.
REQ-027 Clear: all entries sentinel, count 0, done at accept+1, result 1.
REQ-028 full = (count==DEPTH); empty = (count==0); op_valid outside IDLE SHALL be ignored.

Reset
REQ-029 rst SHALL, at any state including mid-operation, force IDLE, count 0, all entries sentinel, done 0, result 0, data_out 0; aborted operation SHALL never signal done.
REQ-030 op_ready SHALL be 0 during a cycle with rst high and 1 the cycle after rst deasserts.

Configuration
REQ-031 Macro SORTED_ROUTER_DROP_MAX_EN defined: insert on full with value < entry[DEPTH-1] SHALL discard entry[DEPTH-1] to data_out, perform REQ-019 insert from idx DEPTH-2, count stays DEPTH, result 1; value >= entry[DEPTH-1] SHALL return result 0, data_out=value, done at accept+1.
REQ-032 Macro undefined: insert on full SHALL return result 0, data_out=op_data, done at accept+1, contents unchanged.

Verification (DATA_W=32, DEPTH=4)
REQ-033 rst, insert 2 -> done at accept+1, count 1, min_out 2, empty 0, last_addr 0.
REQ-034 insert 5,3,9 then insert 1 -> 3 compare cycles, done at accept+4, order 1,3,5,9, full 1.
REQ-035 full {1,3,5,9}, insert 7 -> without macro result 0, unchanged; with macro result 1, order 1,3,5,7, data_out 9.
REQ-036 four removes -> data_out 1,3,5,9 (or 7), then remove on empty -> result 0, data_out FFFFFFFF, empty 1.
REQ-037 insert 4,4(second tagged by timing) then 2 -> order 2,4,4, count 3; clear -> count 0, min_out FFFFFFFF.
REQ-038 rst pulsed during INSERT of 0 into {3,5,9} -> no done, count 0, op_ready 1 next cycle.

Source files
------------

// File: rtl/sorted_value_router_if.sv
// Operation handshake and status bundle for sorted_value_router.
// The master drives operations; the slave (the router) returns completion and status.
interface sorted_value_router_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
);
    logic              op_valid;
    logic [1:0]        op;
    logic [DATA_W-1:0] op_data;
    logic              op_ready;
    logic              done;
    logic              result;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] min_out;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  last_addr;

    modport master (
        output op_valid, op, op_data,
        input  op_ready, done, result, data_out, min_out, count, full, empty, last_addr
    );

    modport slave (
        input  op_valid, op, op_data,
        output op_ready, done, result, data_out, min_out, count, full, empty, last_addr
    );
endinterface

// File: rtl/sorted_value_router.sv
// Ascending sorted register array with multi-cycle insert (walk down) and remove-min (shift up).
// Optional macro SORTED_ROUTER_DROP_MAX_EN: insert on full evicts the current maximum.
module sorted_value_router #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input logic                  clk,
    input logic                  rst,
    sorted_value_router_if.slave rtr_if
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {S_IDLE, S_INSERT, S_REMOVE, S_FINISH} state_e;
    typedef enum logic [1:0] {
        OP_INSERT = 2'b00,
        OP_REMOVE = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    localparam data_t            SENTINEL = '1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    state_e           state_q;
    data_t            entry_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    idx_t             idx_q;
    data_t            val_q;
    logic             grow_q;
    logic             done_q;
    logic             result_q;
    data_t            data_out_q;

    logic             full_d;
    logic             empty_d;
    logic [CNT_W-1:0] last_addr_d;
    idx_t             last_idx_d;
    logic             walk_gt_d;
    logic             walk_end_d;

    assign empty_d     = (count_q == '0);
    assign full_d      = (count_q == DEPTH_C);
    assign last_addr_d = empty_d ? '0 : count_q - 1'b1;
    assign last_idx_d  = idx_t'(last_addr_d);
    assign walk_gt_d   = entry_q[idx_q] > val_q;
    // Remove shift ends once entry[count-2] has taken entry[count-1] (or at once for one entry).
    assign walk_end_d  = (CNT_W'(idx_q) + CNT_W'(2)) >= count_q;

    // NOTE: every register here, including the storage array, is written with non-blocking
    // assignments so each compare in a cycle sees the pre-edge contents of the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset because unused slots must read as the all-ones sentinel.
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= SENTINEL;
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            val_q      <= '0;
            grow_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rtr_if.op_valid) begin
                        case (op_e'(rtr_if.op))
                            OP_INSERT: begin
                                val_q  <= rtr_if.op_data;
                                grow_q <= 1'b1;
                                if (empty_d) begin
                                    entry_q[0] <= rtr_if.op_data;
                                    count_q    <= count_q + 1'b1;
                                    state_q    <= S_FINISH;
                                    done_q     <= 1'b1;
                                    result_q   <= 1'b1;
                                end else if (!full_d) begin
                                    idx_q   <= last_idx_d;
                                    state_q <= S_INSERT;
                                end else begin
`ifdef SORTED_ROUTER_DROP_MAX_EN
                                    if (rtr_if.op_data < entry_q[DEPTH-1]) begin
                                        data_out_q <= entry_q[DEPTH-1];
                                        grow_q     <= 1'b0;
                                        idx_q      <= idx_t'(DEPTH - 2);
                                        state_q    <= S_INSERT;
                                    end else begin
                                        data_out_q <= rtr_if.op_data;
                                        result_q   <= 1'b0;
                                        done_q     <= 1'b1;
                                        state_q    <= S_FINISH;
                                    end
`else
                                    data_out_q <= rtr_if.op_data;
                                    result_q   <= 1'b0;
                                    done_q     <= 1'b1;
                                    state_q    <= S_FINISH;
`endif
                                end
                            end
                            OP_REMOVE: begin
                                if (empty_d) begin
                                    data_out_q <= SENTINEL;
                                    result_q   <= 1'b0;
                                    done_q     <= 1'b1;
                                    state_q    <= S_FINISH;
                                end else begin
                                    data_out_q <= entry_q[0];
                                    idx_q      <= '0;
                                    state_q    <= S_REMOVE;
                                end
                            end
                            OP_CLEAR: begin
                                for (int i = 0; i < DEPTH; i++) entry_q[i] <= SENTINEL;
                                count_q    <= '0;
                                data_out_q <= '0;
                                result_q   <= 1'b1;
                                done_q     <= 1'b1;
                                state_q    <= S_FINISH;
                            end
                            default: begin
                                data_out_q <= '0;
                                result_q   <= 1'b0;
                                done_q     <= 1'b1;
                                state_q    <= S_FINISH;
                            end
                        endcase
                    end
                end
                S_INSERT: begin
                    if (walk_gt_d) begin
                        entry_q[idx_q + 1'b1] <= entry_q[idx_q];
                        if (idx_q == '0) entry_q[0] <= val_q;
                        else             idx_q      <= idx_q - 1'b1;
                    end else begin
                        entry_q[idx_q + 1'b1] <= val_q;
                    end
                    if (!walk_gt_d || idx_q == '0) begin
                        if (grow_q) count_q <= count_q + 1'b1;
                        result_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end
                end
                S_REMOVE: begin
                    entry_q[idx_q] <= entry_q[idx_q + 1'b1];
                    if (walk_end_d) begin
                        entry_q[last_idx_d] <= SENTINEL;
                        count_q  <= count_q - 1'b1;
                        result_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rtr_if.op_ready  = (state_q == S_IDLE) && !rst;
    assign rtr_if.done      = done_q;
    assign rtr_if.result    = result_q;
    assign rtr_if.data_out  = data_out_q;
    assign rtr_if.min_out   = entry_q[0];
    assign rtr_if.count     = count_q;
    assign rtr_if.full      = full_d;
    assign rtr_if.empty     = empty_d;
    assign rtr_if.last_addr = last_addr_d;
endmodule
